obi_slave_mem: RTL and testbench

OBI_SLAVE_MEM -- requirements
Module: obi_slave_mem

---
 rtl/obi_slave_mem.sv | 101 ++++++++++
 tb/tb_obi_slave_mem.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/obi_slave_mem.sv
// OBI word-addressed memory slave with a fixed-latency, in-order response pipeline
// and an outstanding-request limit that lets a retiring response free its slot the same cycle.
module obi_slave_mem #(
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          NUM_WORDS       = 256,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int          IDX_W = $clog2(NUM_WORDS);
  localparam int          OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] SPAN  = 33'(4 * NUM_WORDS);

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic [31:0]          mem [NUM_WORDS];
  logic [LATENCY:1]     vld_pipe;
  rsp_t [LATENCY:1]     rsp_pipe;
  rsp_t                 rsp_new;
  logic [OW-1:0]        outst;
  logic [32:0]          offs;
  logic                 in_range;
  logic                 acc;
  logic [IDX_W-1:0]     idx;

  // A 33-bit difference makes addresses below the base wrap to huge values, so one compare covers both bounds.
  assign offs     = {1'b0, addr_i} - {1'b0, BASE_ADDR & 32'hFFFF_FFFC};
  assign in_range = offs < SPAN;
  assign idx      = offs[IDX_W+1:2];

  assign gnt_o = ~rst_i & req_i & ~stall_i &
                 ((outst < OW'(MAX_OUTSTANDING)) | rvalid_o);
  assign acc   = gnt_o;

  always_comb begin
    rsp_new = '0;
    if (acc && !in_range)  rsp_new.err  = 1'b1;
    else if (acc && !we_i) rsp_new.data = mem[idx];
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (acc && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
      rsp_pipe <= '0;
    end else begin
      vld_pipe[1] <= acc;
      rsp_pipe[1] <= rsp_new;
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        rsp_pipe[s] <= rsp_pipe[s-1];
      end
    end
  end

  assign rvalid_o = vld_pipe[LATENCY];
  assign err_o    = rsp_pipe[LATENCY].err;
  assign rdata_o  = rsp_pipe[LATENCY].data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst <= '0;
    end else begin
      case ({acc, rvalid_o})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  a_outst_max: assert property (@(posedge clk_i) disable iff (rst_i)
    outst <= OW'(MAX_OUTSTANDING));
  a_outst_min: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rvalid_o && outst == '0));

endmodule

// File: tb/tb_obi_slave_mem.sv
// Directed bench for obi_slave_mem: one LATENCY=2/MAX=2 instance and one LATENCY=3/MAX=1 instance.
module tb_obi_slave_mem;

  logic        clk, rst;
  logic        req, req3, we, stall;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err, gnt3, rvalid3, err3;
  logic [31:0] rdata, rdata3;
  int          n_vec, n_err;

  logic [31:0] ca [6];
  logic [31:0] cd [6];
  logic        ce [6];

  obi_slave_mem #(.BASE_ADDR(32'h1000), .NUM_WORDS(16), .LATENCY(2), .MAX_OUTSTANDING(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .stall_i(stall), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err));

  obi_slave_mem #(.BASE_ADDR(32'h1000), .NUM_WORDS(16), .LATENCY(3), .MAX_OUTSTANDING(1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .stall_i(stall), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: grant now, silence until the latency expires, then one response.
  task automatic xact(input bit sel, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e,
                      input string tag);
    int lat = sel ? 3 : 2;
    we = w; be = b; addr = a; wdata = d;
    if (sel) req3 = 1'b1; else req = 1'b1;
    @(negedge clk);
    chk({tag, ".gnt"}, sel ? gnt3 : gnt, 32'd1);
    step();
    req = 1'b0; req3 = 1'b0;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk({tag, ".early"}, sel ? rvalid3 : rvalid, 32'd0);
      step();
    end
    @(negedge clk);
    chk({tag, ".rvalid"}, sel ? rvalid3 : rvalid, 32'd1);
    chk({tag, ".rdata"},  sel ? rdata3  : rdata,  exp_d);
    chk({tag, ".err"},    sel ? err3    : err,    {31'd0, exp_e});
    step();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; req = 1'b1; req3 = 1'b0; we = 1'b1; be = 4'hF;
    addr = 32'h1010; wdata = 32'hDEADBEEF; stall = 1'b0;

    @(negedge clk);
    chk("rst.gnt", gnt, 32'd0);
    chk("rst.rvalid", rvalid, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.err", err, 32'd0);
    step();
    rst = 1'b0;

    xact(0, 1, 4'hF, 32'h1010, 32'hDEADBEEF, 32'h0, 0, "wr10");
    xact(0, 0, 4'h0, 32'h1010, 32'h0, 32'hDEADBEEF, 0, "rd10");
    xact(0, 1, 4'hF, 32'h1014, 32'h11223344, 32'h0, 0, "wr14");
    xact(0, 1, 4'b0101, 32'h1014, 32'hAABBCCDD, 32'h0, 0, "wr14be");
    xact(0, 0, 4'h0, 32'h1014, 32'h0, 32'h11BB33DD, 0, "rd14be");
    xact(0, 1, 4'h0, 32'h1014, 32'hFFFFFFFF, 32'h0, 0, "wr14be0");
    xact(0, 0, 4'h0, 32'h1014, 32'h0, 32'h11BB33DD, 0, "rd14be0");
    xact(0, 1, 4'hF, 32'h1000, 32'h0BADF00D, 32'h0, 0, "wr00");
    xact(0, 1, 4'hF, 32'h103C, 32'h12345678, 32'h0, 0, "wr3c");
    xact(0, 0, 4'h0, 32'h103C, 32'h0, 32'h12345678, 0, "rd3c");
    xact(0, 0, 4'h0, 32'h1013, 32'h0, 32'hDEADBEEF, 0, "rd13");
    xact(0, 0, 4'h0, 32'h1040, 32'h0, 32'h0, 1, "rdoor");
    xact(0, 1, 4'hF, 32'h1040, 32'h55555555, 32'h0, 1, "wroor");
    xact(0, 0, 4'h0, 32'h1000, 32'h0, 32'h0BADF00D, 0, "rd00");
    xact(0, 0, 4'h0, 32'h0FFC, 32'h0, 32'h0, 1, "rdlow");

    // Back-to-back reads: grant every cycle, responses every cycle from cycle 2, in order.
    ca = '{32'h1010, 32'h1014, 32'h1000, 32'h103C, 32'h1040, 32'h1010};
    cd = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0BADF00D, 32'h12345678, 32'h0, 32'hDEADBEEF};
    ce = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 9; c++) begin
      we = 1'b0;
      if (c < 6) begin req = 1'b1; addr = ca[c]; end
      else req = 1'b0;
      @(negedge clk);
      if (c < 6) chk("b2b.gnt", gnt, 32'd1);
      if (c >= 2 && c < 8) begin
        chk("b2b.rvalid", rvalid, 32'd1);
        chk("b2b.rdata", rdata, cd[c-2]);
        chk("b2b.err", err, {31'd0, ce[c-2]});
      end else begin
        chk("b2b.idle", rvalid, 32'd0);
      end
      step();
    end

    // Stall blocks grants but leaves the in-flight response alone.
    req = 1'b1; we = 1'b0; addr = 32'h1010; stall = 1'b1;
    @(negedge clk); chk("stall.gnt0", gnt, 32'd0); step();
    stall = 1'b0;
    @(negedge clk); chk("stall.gnt1", gnt, 32'd1); step();
    stall = 1'b1;
    @(negedge clk); chk("stall.gnt2", gnt, 32'd0); chk("stall.early", rvalid, 32'd0); step();
    stall = 1'b0; req = 1'b0;
    @(negedge clk); chk("stall.rvalid", rvalid, 32'd1); chk("stall.rdata", rdata, 32'hDEADBEEF); step();

    // Reset with two reads in flight: both responses are dropped.
    req = 1'b1; addr = 32'h1010;
    @(negedge clk); chk("mid.gnt0", gnt, 32'd1); step();
    addr = 32'h1014;
    @(negedge clk); chk("mid.gnt1", gnt, 32'd1); step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid.rst.gnt", gnt, 32'd0);
    chk("mid.rst.rvalid", rvalid, 32'd0);
    chk("mid.rst.rdata", rdata, 32'd0);
    step();
    rst = 1'b0; req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("mid.quiet", rvalid, 32'd0); step();
    end
    xact(0, 0, 4'h0, 32'h1010, 32'h0, 32'hDEADBEEF, 0, "mid.fresh");

    // LATENCY=3, one outstanding: req held high, grants/responses every third cycle.
    xact(1, 1, 4'hF, 32'h1008, 32'hCAFEF00D, 32'h0, 0, "l3.wr");
    we = 1'b0; addr = 32'h1008;
    for (int c = 0; c < 14; c++) begin
      req3 = (c <= 9);
      @(negedge clk);
      chk("l3.gnt", gnt3, {31'd0, (c % 3 == 0) && (c <= 9)});
      chk("l3.rvalid", rvalid3, {31'd0, (c % 3 == 0) && (c >= 3) && (c <= 12)});
      if ((c % 3 == 0) && (c >= 3) && (c <= 12)) chk("l3.rdata", rdata3, 32'hCAFEF00D);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
